// File: rtl/debounce_pkg.sv
// ============================================================================
// debounce_pkg : shared state encoding and defaults for the debounce block
// Revision     : 1.0
// ============================================================================
`default_nettype none

package debounce_pkg;

  localparam int DEFAULT_STABLE_CYCLES = 8;
  localparam int DEFAULT_CNT_W         = 4;

  localparam logic [1:0] ST_IDLE_LOW  = 2'b00;
  localparam logic [1:0] ST_WAIT_HIGH = 2'b01;
  localparam logic [1:0] ST_HIGH      = 2'b10;
  localparam logic [1:0] ST_WAIT_LOW  = 2'b11;

  typedef enum logic [1:0] {
    IDLE_LOW  = ST_IDLE_LOW,
    WAIT_HIGH = ST_WAIT_HIGH,
    HIGH      = ST_HIGH,
    WAIT_LOW  = ST_WAIT_LOW
  } state_e;

  function automatic logic state_is_wait(input state_e s);
    return (s == WAIT_HIGH) || (s == WAIT_LOW);
  endfunction

  // The accepted level stays high until a release is fully qualified.
  function automatic logic state_level(input state_e s);
    return (s == HIGH) || (s == WAIT_LOW);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// sync_2ff : two-flop synchronizer for a single asynchronous level input
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

`default_nettype wire

// File: rtl/debounce_pulse.sv
// ============================================================================
// debounce_pulse : synchronize and debounce a button, emit one-cycle edge pulses
// Revision       : 1.0
// ============================================================================
`default_nettype none

module debounce_pulse
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int CNT_W         = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic level_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic btn_s;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (btn_s)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             level_q, level_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    case (state_q)
      IDLE_LOW: begin
        if (btn_s) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!btn_s) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_LAST) begin
          // >= rather than == so an out-of-range count still terminates
          state_d = HIGH;
          cnt_d   = '0;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HIGH: begin
        if (!btn_s) begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (btn_s) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
      end
    endcase

    level_d = state_level(state_d);
    busy_d  = state_is_wait(state_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      level_q <= level_d;
      busy_q  <= busy_d;
    end
  end

  assign level_out  = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign busy       = busy_q;

endmodule

`default_nettype wire

// File: doc/debounce_pulse.md
Name: debounce_pulse

Overview:
- Upstream conditioning stage for the team's enabled D flip-flop registers (1/2/4-bit).
- Takes a raw asynchronous push-button or switch level and synchronizes it into `clk`.
- Debounces it with a stability counter and produces two outputs:
  - a clean level;
  - a single-cycle pulse that drives the `enabled` input of a downstream D-register, so the register captures exactly once per press.

Parameters:
- STABLE_CYCLES, 8: consecutive synchronized cycles the input must hold a new value before it is accepted. Legal range 2..(2^CNT_W - 1).
- CNT_W, 4: width of the stability counter.

Ports:
- clk, input, 1: single clock, rising edge.
- reset, input, 1: asynchronous, active-low reset (0 = reset).
- btn_in, input, 1: raw asynchronous button/switch level.
- level_out, output, 1: debounced level.
- rise_pulse, output, 1: one-cycle pulse on an accepted 0->1 transition. This is the downstream register's `enabled`.
- fall_pulse, output, 1: one-cycle pulse on an accepted 1->0 transition.
- busy, output, 1: high while a candidate transition is being qualified (WAIT_HIGH or WAIT_LOW).

Behaviour:
- Reset: while `reset` = 0, asynchronously force:
  - sync flops = 0, state = IDLE_LOW, cnt = 0;
  - level_out = 0, rise_pulse = 0, fall_pulse = 0, busy = 0.
- Reset release: behaviour resumes on the first rising clk edge after `reset` returns to 1. Reset asserted mid-qualification aborts the qualification and emits no pulse.
- Synchronizer: two flops, s1 <= btn_in, s2 <= s1. The FSM sees only s2 (btn_s), two edges after btn_in is first sampled.
- FSM states: IDLE_LOW, WAIT_HIGH, HIGH, WAIT_LOW. All outputs are registered.
  - IDLE_LOW: if btn_s = 1, go to WAIT_HIGH with cnt <= 0.
  - WAIT_HIGH:
    - btn_s = 0: go back to IDLE_LOW (glitch rejected), cnt <= 0, no pulse.
    - btn_s = 1 and cnt = STABLE_CYCLES-1: go to HIGH and set rise_pulse <= 1 for exactly one cycle.
    - otherwise: cnt <= cnt+1.
  - HIGH: if btn_s = 0, go to WAIT_LOW with cnt <= 0.
  - WAIT_LOW: mirror of WAIT_HIGH.
    - btn_s = 1: go back to HIGH.
    - btn_s = 0 and cnt = STABLE_CYCLES-1: go to IDLE_LOW and set fall_pulse <= 1 for one cycle.
- Output definitions:
  - level_out = 1 in HIGH and WAIT_LOW, 0 otherwise.
  - busy = 1 in WAIT_HIGH and WAIT_LOW.
- Latency: btn_in rising, stable from sampling edge E0:
  - WAIT_HIGH is entered at E2;
  - HIGH and rise_pulse are reached at E(2+STABLE_CYCLES);
  - rise_pulse is high for exactly one clock period, and level_out rises in the same cycle.
- Pulse rules:
  - rise_pulse and fall_pulse are never high together.
  - Pulses are never back-to-back. The minimum spacing is STABLE_CYCLES+1 cycles.
- Counter: cnt never exceeds STABLE_CYCLES-1. No wrap-around is reachable. It saturates defensively if an illegal state is reached.
- Illegal state encoding: recover to IDLE_LOW on the next edge with all outputs 0.
- Input held constant: no pulses are generated.

Decomposition:
- Shared package debounce_pkg:
  - state encoding constants ST_IDLE_LOW = 2'b00, ST_WAIT_HIGH = 2'b01, ST_HIGH = 2'b10, ST_WAIT_LOW = 2'b11;
  - default STABLE_CYCLES.
- One sub-module: sync_2ff.
  - Ports: clk, reset (async active-low), d, q.
  - Reusable for every asynchronous input on the board.
- The FSM and counter stay in debounce_pulse.

Test Plan:
- Reset: hold `reset` = 0 with btn_in = 1 for 3 cycles. All outputs must be 0 and state IDLE_LOW. Release reset: rise_pulse arrives exactly 2+8 edges after the first sampling edge.
- Clean press (STABLE_CYCLES = 8): btn_in 0->1 held for 20 cycles. Required: rise_pulse = 1 for one cycle at E10, level_out = 1 from E10, busy = 1 from E2 until E10. A downstream 4-bit enabled register with D = 4'b1010 must load it exactly once.
- Bounce rejection: btn_in toggles 1,0,1,0 with 3-cycle highs, then stays 0. Required: busy toggles, no rise_pulse, level_out stays 0.
- Release: from HIGH, btn_in 1->0 held. Required: fall_pulse at E(2+8), level_out = 0 in the same cycle, rise_pulse stays 0.
- Reset mid-qualification: press, then assert `reset` = 0 while cnt = 5, release after 2 cycles with btn_in still 1. Required: no pulse during reset, outputs 0 immediately (asynchronous), and a fresh qualification giving rise_pulse 10 edges after release.
- Boundary at STABLE_CYCLES = 2: 3-cycle press is accepted with rise_pulse at E4. A 1-cycle glitch is rejected.
